rgb_pwm_periph: RTL and testbench

Memory-mapped RGB LED peripheral that sits on the processor's data bus as a responder. It accepts word-addressed loads and stores, holds per-channel duty registers, and drives the board RGB pins with glitch-free PWM. It also exposes free-running microsecond and millisecond counters for firmware timing loops, such as the sine-fade program.

---
 rtl/rgb_pwm_periph_if.sv | 21 ++
 rtl/rgb_pwm_periph.sv | 152 +++++++++++++++
 tb/tb_rgb_pwm_periph.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_pwm_periph_if.sv
// rtl/rgb_pwm_periph_if.sv - request/response bus bundle for the RGB PWM peripheral
interface rgb_pwm_periph_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wmask;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_wmask,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_wmask,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/rgb_pwm_periph.sv
// rtl/rgb_pwm_periph.sv - memory-mapped RGB PWM LED driver with microsecond/millisecond timers
module rgb_pwm_periph #(
   parameter int PWM_BITS = 8,
   parameter int CLK_HZ   = 12000000
) (
   input  logic              clk,
   input  logic              reset,
   rgb_pwm_periph_if.slave   bus,
   output logic              RGB_R,
   output logic              RGB_G,
   output logic              RGB_B
);

   localparam int PRE_MAX = CLK_HZ / 1000000 - 1;
   localparam int PRE_W   = (PRE_MAX > 0) ? $clog2(PRE_MAX + 1) : 1;
   localparam logic [PWM_BITS-1:0] CNT_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

   typedef enum logic {IDLE, RESP} state_t;

   state_t              state;
   logic                req_ready_q;
   logic                rsp_valid_q;
   logic [31:0]         rsp_rdata_q;
   logic                lat_we;
   logic [1:0]          lat_addr;
   logic [23:0]         lat_wdata;
   logic [2:0]          lat_wmask;

   logic [PWM_BITS-1:0] pend_r, pend_g, pend_b;
   logic [PWM_BITS-1:0] act_r, act_g, act_b;
   logic                ctrl_en, ctrl_inv;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [PRE_W-1:0]    prescaler;
   logic [9:0]          ms_sub;
   logic [31:0]         micros, millis;

   logic [31:0]         duty_word;
   logic [31:0]         rd_value;
   logic                pwm_wrap, us_tick;
   logic                on_r, on_g, on_b;

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;

   assign duty_word = {8'd0, 8'(pend_b), 8'(pend_g), 8'(pend_r)};
   assign pwm_wrap  = (pwm_cnt == CNT_LAST);
   assign us_tick   = (prescaler == PRE_W'(PRE_MAX));
   assign on_r      = (pwm_cnt < act_r);
   assign on_g      = (pwm_cnt < act_g);
   assign on_b      = (pwm_cnt < act_b);

   always_comb begin
      rd_value = 32'd0;
      case (bus.req_addr)
         2'd0:    rd_value = duty_word;
         2'd1:    rd_value = {30'd0, ctrl_inv, ctrl_en};
         2'd2:    rd_value = micros;
         default: rd_value = millis;
      endcase
   end

   // Loads are answered with state sampled at the accept edge; stores commit on leaving RESP.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
         lat_we      <= 1'b0;
         lat_addr    <= 2'd0;
         lat_wdata   <= 24'd0;
         lat_wmask   <= 3'd0;
         pend_r      <= '0;
         pend_g      <= '0;
         pend_b      <= '0;
         ctrl_en     <= 1'b0;
         ctrl_inv    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  state       <= RESP;
                  req_ready_q <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= bus.req_we ? 32'd0 : rd_value;
                  lat_we      <= bus.req_we;
                  lat_addr    <= bus.req_addr;
                  lat_wdata   <= bus.req_wdata[23:0];
                  lat_wmask   <= bus.req_wmask[2:0];
               end
            end
            RESP: begin
               state       <= IDLE;
               req_ready_q <= 1'b1;
               rsp_valid_q <= 1'b0;
               rsp_rdata_q <= 32'd0;
               if (lat_we && lat_addr == 2'd0) begin
                  if (lat_wmask[0]) pend_r <= lat_wdata[PWM_BITS-1:0];
                  if (lat_wmask[1]) pend_g <= lat_wdata[8 +: PWM_BITS];
                  if (lat_wmask[2]) pend_b <= lat_wdata[16 +: PWM_BITS];
               end
               if (lat_we && lat_addr == 2'd1 && lat_wmask[0]) begin
                  ctrl_en  <= lat_wdata[0];
                  ctrl_inv <= lat_wdata[1];
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Active duty only follows pending at the wrap, so a period is never cut short.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pwm_cnt <= '0;
         act_r   <= '0;
         act_g   <= '0;
         act_b   <= '0;
         RGB_R   <= 1'b1;
         RGB_G   <= 1'b1;
         RGB_B   <= 1'b1;
      end else begin
         pwm_cnt <= pwm_wrap ? '0 : pwm_cnt + 1'b1;
         if (pwm_wrap) begin
            act_r <= pend_r;
            act_g <= pend_g;
            act_b <= pend_b;
         end
         RGB_R <= ctrl_en ? ~(on_r ^ ctrl_inv) : ~ctrl_inv;
         RGB_G <= ctrl_en ? ~(on_g ^ ctrl_inv) : ~ctrl_inv;
         RGB_B <= ctrl_en ? ~(on_b ^ ctrl_inv) : ~ctrl_inv;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prescaler <= '0;
         ms_sub    <= 10'd0;
         micros    <= 32'd0;
         millis    <= 32'd0;
      end else begin
         prescaler <= us_tick ? '0 : prescaler + 1'b1;
         if (us_tick) begin
            micros <= micros + 32'd1;
            ms_sub <= (ms_sub == 10'd999) ? 10'd0 : ms_sub + 10'd1;
            if (ms_sub == 10'd999) millis <= millis + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_rgb_pwm_periph.sv
// tb/tb_rgb_pwm_periph.sv - randomized self-checking bench for rgb_pwm_periph
module tb_rgb_pwm_periph;
   logic clk = 1'b0;
   logic reset;
   logic rgb_r, rgb_g, rgb_b;
   logic [31:0] cyc;
   logic [31:0] m_duty, m_ctrl;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   rgb_pwm_periph_if bus ();

   rgb_pwm_periph #(.PWM_BITS(8), .CLK_HZ(12000000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .RGB_R (rgb_r),
      .RGB_G (rgb_g),
      .RGB_B (rgb_b)
   );

   // Rising edges since reset release: drives the timer and PWM phase model.
   always @(posedge clk or posedge reset)
      if (reset) cyc <= 32'd0;
      else       cyc <= cyc + 32'd1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [3:0] m);
      logic [31:0] r;
      for (int i = 0; i < 4; i++)
         r[i*8 +: 8] = m[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
      return r;
   endfunction

   function automatic logic [31:0] exp_low(input logic [7:0] d, input logic [31:0] c);
      if (!c[0]) return c[1] ? 32'd255 : 32'd0;
      return c[1] ? 32'd255 - 32'(d) : 32'(d);
   endfunction

   task automatic xfer(input bit we, input logic [1:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wmask, output logic [31:0] rdata,
                       output logic [31:0] at_cyc);
      int n = 0;
      @(negedge clk);
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("req_ready", 32'(bus.req_ready), 32'd1);
      at_cyc        = cyc;
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_wmask = wmask;
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
      rdata = bus.rsp_rdata;
      if (we) begin
         check("store_rdata", rdata, 32'd0);
         if (addr == 2'd0) m_duty = merge(m_duty, wdata, wmask) & 32'h00FF_FFFF;
         if (addr == 2'd1) m_ctrl = merge(m_ctrl, wdata, wmask) & 32'h0000_0003;
      end
   endtask

   task automatic wr(input logic [1:0] addr, input logic [31:0] wdata, input logic [3:0] wmask);
      logic [31:0] rd, at;
      xfer(1'b1, addr, wdata, wmask, rd, at);
   endtask

   task automatic rd_check(input string tag, input logic [1:0] addr);
      logic [31:0] rd, at, exp;
      xfer(1'b0, addr, 32'd0, 4'd0, rd, at);
      case (addr)
         2'd0:    exp = m_duty;
         2'd1:    exp = m_ctrl;
         2'd2:    exp = at / 12;
         default: exp = at / 12 / 1000;
      endcase
      check(tag, rd, exp);
   endtask

   task automatic count_low(output int r, output int g, output int b);
      r = 0; g = 0; b = 0;
      repeat (255) begin
         @(negedge clk);
         r += int'(!rgb_r);
         g += int'(!rgb_g);
         b += int'(!rgb_b);
      end
   endtask

   task automatic check_pins(input string tag);
      int r, g, b;
      repeat (300) @(negedge clk);
      count_low(r, g, b);
      check({tag, "_r"}, 32'(r), exp_low(m_duty[7:0], m_ctrl));
      check({tag, "_g"}, 32'(g), exp_low(m_duty[15:8], m_ctrl));
      check({tag, "_b"}, 32'(b), exp_low(m_duty[23:16], m_ctrl));
   endtask

   initial begin
      logic [31:0] rd, at, e0, exp_us;
      int lo, n;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = 2'd0;
      bus.req_wdata = 32'd0;
      bus.req_wmask = 4'd0;
      m_duty = 32'd0;
      m_ctrl = 32'd0;
      reset  = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(bus.req_ready), 32'd1);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rdata", bus.rsp_rdata, 32'd0);
      check("rst_pins", 32'({rgb_r, rgb_g, rgb_b}), 32'd7);
      reset = 1'b0;

      // Store in flight when reset hits: must vanish without a response.
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 2'd0;
      bus.req_wdata = 32'h00FF_FFFF;
      bus.req_wmask = 4'hF;
      @(posedge clk);
      #1 reset = 1'b1;
      bus.req_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
         check("midrst_pins", 32'({rgb_r, rgb_g, rgb_b}), 32'd7);
      end
      reset = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 32'(bus.req_ready), 32'd1);
      rd_check("duty_discarded", 2'd0);

      wr(2'd0, 32'h0040_80FF, 4'hF);
      rd_check("duty_full", 2'd0);
      wr(2'd0, 32'h0000_1100, 4'b0010);
      rd_check("duty_masked", 2'd0);

      for (int i = 0; i < 60; i++) begin
         logic [1:0] a;
         a = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) wr(a, $urandom, 4'($urandom));
         else                           rd_check("rand_load", a);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      for (int a = 0; a < 4; a++) rd_check("rand_final", 2'(a));

      wr(2'd0, 32'h0000_80FF, 4'hF);
      wr(2'd1, 32'd1, 4'h1);
      check_pins("pwm");

      wr(2'd0, 32'h0000_0080, 4'h1);
      repeat (300) @(negedge clk);
      n = 0;
      @(negedge clk);
      while ((cyc - 32'd1) % 255 != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("window_sync", 32'((cyc - 32'd1) % 255), 32'd0);
      lo = 0;
      for (int i = 0; i < 255; i++) begin
         if (i > 0) @(negedge clk);
         lo += int'(!rgb_r);
         if (i == 97) begin
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b1;
            bus.req_addr  = 2'd0;
            bus.req_wdata = 32'h0000_0010;
            bus.req_wmask = 4'h1;
         end
         if (i == 98) begin
            bus.req_valid = 1'b0;
            check("glitch_rsp", 32'(bus.rsp_valid), 32'd1);
         end
      end
      check("glitch_cur", 32'(lo), 32'd128);
      m_duty = merge(m_duty, 32'h0000_0010, 4'h1);
      count_low(lo, n, n);
      check("glitch_next", 32'(lo), 32'd16);

      wr(2'd1, 32'd3, 4'h1);
      check_pins("inv");
      wr(2'd1, 32'd2, 4'h1);
      check_pins("inv_off");
      wr(2'd1, 32'd0, 4'h1);
      check_pins("off");

      n = 0;
      while (cyc < 32'd11999 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      xfer(1'b0, 2'd2, 32'd0, 4'd0, rd, at);
      check("micros_12000", rd, at / 12);
      check("micros_12000_abs", rd, 32'd1000);
      rd_check("millis", 2'd3);

      @(negedge clk);
      e0 = cyc;
      force dut.micros = 32'hFFFF_FFFF;
      #1 release dut.micros;
      repeat (30) @(negedge clk);
      xfer(1'b0, 2'd2, 32'd0, 4'd0, rd, at);
      exp_us = 32'hFFFF_FFFF + at / 12 - e0 / 12;
      check("micros_wrap", rd, exp_us);
      rd_check("millis_after_wrap", 2'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL timeout: got=running exp=finished");
      $fatal(1);
   end
endmodule
